mem_arbiter: RTL and testbench

//  Shares the single main-memory port between the instruction-cache and data-cache miss paths.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter_if.sv | 55 +++++
 rtl/mem_arbiter_lat_counter.sv | 34 +++
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the I/D-cache main-memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned LINE_W_DEF  = 128;
    localparam int unsigned MEM_LAT_DEF = 5;

    // Arbiter sequencing states; encodings are shared with the cache controllers.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_FILL = 2'd1,
        D_WB   = 2'd2,
        D_FILL = 2'd3
    } arb_state_t;

    // Width of a counter that must hold 0..lat inclusive.
    function automatic int unsigned cnt_width(input int unsigned lat);
        int unsigned w;
        w = $clog2(lat + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request/ack buses plus the main-memory port of the arbiter.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LINE_W = LINE_W_DEF
) ();

    // I-cache fill path
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [LINE_W-1:0] i_line;

    // D-cache fill path with optional dirty writeback
    logic              d_req;
    logic              d_wb;
    logic [ADDR_W-1:0] d_addr;
    logic [ADDR_W-1:0] d_wbaddr;
    logic [LINE_W-1:0] d_wdata;
    logic              d_ack;
    logic [LINE_W-1:0] d_line;

    // Main-memory port
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;

    logic              busy;

    // Arbiter side
    modport slave (
        input  i_req, i_addr,
        input  d_req, d_wb, d_addr, d_wbaddr, d_wdata,
        input  mem_rdata,
        output i_ack, i_line,
        output d_ack, d_line,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );

    // Cache/memory side
    modport master (
        output i_req, i_addr,
        output d_req, d_wb, d_addr, d_wbaddr, d_wdata,
        output mem_rdata,
        input  i_ack, i_line,
        input  d_ack, d_line,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );

endinterface

// File: rtl/mem_arbiter_lat_counter.sv
// Transaction cycle counter: load to 1 on phase entry, count up to MEM_LAT, flag the last cycle.
module lat_counter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic clear,
    output logic done_c
);

    localparam int unsigned CW = cnt_width(MEM_LAT);

    logic [CW-1:0] cnt;

    // Counts only while a phase is running (cnt != 0) and saturates at MEM_LAT.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(1);
        end else if (clear) begin
            cnt <= '0;
        end else if ((cnt != '0) && (cnt < CW'(MEM_LAT))) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Last cycle of the current memory phase.
    assign done_c = (cnt == CW'(MEM_LAT));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency main-memory port between I-cache fills and D-cache
// writeback+fill requests. D has fixed priority over I; every ack cycle is a
// turnaround with no new grant.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned LINE_W  = LINE_W_DEF,
    parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    arb_state_t        state, state_nxt;

    logic              cnt_load, cnt_clear, cnt_done;

    logic              i_ack_q,     i_ack_nxt;
    logic              d_ack_q,     d_ack_nxt;
    logic [LINE_W-1:0] i_line_q,    i_line_nxt;
    logic [LINE_W-1:0] d_line_q,    d_line_nxt;
    logic              mem_en_q,    mem_en_nxt;
    logic              mem_we_q,    mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_nxt;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_nxt;
    logic              busy_q,      busy_nxt;

    lat_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_counter (
        .clk    (clk),
        .reset  (reset),
        .load   (cnt_load),
        .clear  (cnt_clear),
        .done_c (cnt_done)
    );

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, counter control and next values of every registered output.
    always_comb begin
        state_nxt     = state;
        cnt_load      = 1'b0;
        cnt_clear     = 1'b0;
        i_ack_nxt     = 1'b0;
        d_ack_nxt     = 1'b0;
        i_line_nxt    = i_line_q;
        d_line_nxt    = d_line_q;
        mem_en_nxt    = mem_en_q;
        mem_we_nxt    = mem_we_q;
        mem_addr_nxt  = mem_addr_q;
        mem_wdata_nxt = mem_wdata_q;

        unique case (state)
            IDLE: begin
                // An ack cycle is a turnaround: the requester may still hold req.
                if (!i_ack_q && !d_ack_q) begin
                    if (bus.d_req && bus.d_wb) begin
                        state_nxt     = D_WB;
                        cnt_load      = 1'b1;
                        mem_en_nxt    = 1'b1;
                        mem_we_nxt    = 1'b1;
                        mem_addr_nxt  = bus.d_wbaddr;
                        mem_wdata_nxt = bus.d_wdata;
                    end else if (bus.d_req) begin
                        state_nxt     = D_FILL;
                        cnt_load      = 1'b1;
                        mem_en_nxt    = 1'b1;
                        mem_we_nxt    = 1'b0;
                        mem_addr_nxt  = bus.d_addr;
                    end else if (bus.i_req) begin
                        state_nxt     = I_FILL;
                        cnt_load      = 1'b1;
                        mem_en_nxt    = 1'b1;
                        mem_we_nxt    = 1'b0;
                        mem_addr_nxt  = bus.i_addr;
                    end
                end
            end

            I_FILL: begin
                if (cnt_done) begin
                    state_nxt  = IDLE;
                    cnt_clear  = 1'b1;
                    i_line_nxt = bus.mem_rdata;
                    i_ack_nxt  = 1'b1;
                    mem_en_nxt = 1'b0;
                    mem_we_nxt = 1'b0;
                end
            end

            D_WB: begin
                // Chain straight into the fill with no idle gap.
                if (cnt_done) begin
                    state_nxt    = D_FILL;
                    cnt_load     = 1'b1;
                    mem_we_nxt   = 1'b0;
                    mem_addr_nxt = bus.d_addr;
                end
            end

            D_FILL: begin
                if (cnt_done) begin
                    state_nxt  = IDLE;
                    cnt_clear  = 1'b1;
                    d_line_nxt = bus.mem_rdata;
                    d_ack_nxt  = 1'b1;
                    mem_en_nxt = 1'b0;
                    mem_we_nxt = 1'b0;
                end
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_line_q    <= '0;
            d_line_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            i_ack_q     <= i_ack_nxt;
            d_ack_q     <= d_ack_nxt;
            i_line_q    <= i_line_nxt;
            d_line_q    <= d_line_nxt;
            mem_en_q    <= mem_en_nxt;
            mem_we_q    <= mem_we_nxt;
            mem_addr_q  <= mem_addr_nxt;
            mem_wdata_q <= mem_wdata_nxt;
            busy_q      <= busy_nxt;
        end
    end

    assign bus.i_ack     = i_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.i_line    = i_line_q;
    assign bus.d_line    = d_line_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts memory
// phases and acks; a monitor compares whatever the DUT presents.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 128;
    localparam int L  = 5;
    localparam int L1 = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();
    mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus1 ();

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_LAT(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_LAT(L1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;
    bit mon_on = 1'b0;

    typedef struct {
        int          cyc;
        bit          we;
        logic [31:0] addr;
        logic [127:0] wdata;
    } txn_t;

    typedef struct {
        int           cyc;
        logic [127:0] line;
    } ack_t;

    txn_t txq[$];
    ack_t iq[$];
    ack_t dq[$];

    logic [127:0] refmem [logic [31:0]];
    logic [127:0] devmem [logic [31:0]];

    task automatic check(input bit ok, input string name,
                         input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] dflt(input logic [31:0] a);
        return {a, ~a, a ^ 32'hA5A5_5A5A, a + 32'h1234_0000};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [31:0] raddr();
        logic [31:0] r;
        r = 32'($urandom_range(1, 7));
        return r << 8;
    endfunction

    function automatic logic [127:0] ref_rd(input logic [31:0] a);
        return refmem.exists(a) ? refmem[a] : dflt(a);
    endfunction

    // Fixed-latency memory for the MEM_LAT=5 DUT: data only valid in the last cycle.
    initial begin
        int dcnt;
        dcnt = 0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_en) begin
                dcnt = (dcnt == 0 || dcnt == L) ? 1 : dcnt + 1;
                if (dcnt == L && !bus.mem_we)
                    bus.mem_rdata = devmem.exists(bus.mem_addr) ? devmem[bus.mem_addr]
                                                                : dflt(bus.mem_addr);
                else
                    bus.mem_rdata = rnd128();
                if (dcnt == L && bus.mem_we)
                    devmem[bus.mem_addr] = bus.mem_wdata;
            end else begin
                dcnt = 0;
                bus.mem_rdata = rnd128();
            end
        end
    end

    assign bus1.mem_rdata = dflt(bus1.mem_addr);

    // Monitor: pops expectations whenever a memory phase starts or an ack appears.
    initial begin
        int   tcnt;
        txn_t cur;
        ack_t ea;
        logic [31:0]  h_addr;
        bit           h_we;
        logic [127:0] h_wd;
        tcnt = 0;
        forever begin
            @(negedge clk);
            if (!mon_on) begin
                tcnt = 0;
            end else begin
                if (bus.mem_en) begin
                    if (tcnt == 0 || tcnt == L) begin
                        tcnt = 1;
                        if (txq.size() == 0) begin
                            check(1'b0, "unexpected_txn", bus.mem_addr, 0);
                        end else begin
                            cur = txq.pop_front();
                            check(cyc == cur.cyc, "txn_start_cycle", cyc, cur.cyc);
                            check(bus.mem_we == cur.we, "txn_we", bus.mem_we, cur.we);
                            check(bus.mem_addr == cur.addr, "txn_addr", bus.mem_addr, cur.addr);
                            if (cur.we)
                                check(bus.mem_wdata == cur.wdata, "txn_wdata", bus.mem_wdata, cur.wdata);
                            check(bus.busy == 1'b1, "busy_in_txn", bus.busy, 1);
                        end
                        h_addr = bus.mem_addr;
                        h_we   = bus.mem_we;
                        h_wd   = bus.mem_wdata;
                    end else begin
                        tcnt++;
                        if (bus.mem_addr != h_addr || bus.mem_we != h_we || bus.mem_wdata != h_wd)
                            check(1'b0, "txn_stable_addr", bus.mem_addr, h_addr);
                    end
                end else begin
                    if (tcnt != 0 && tcnt != L)
                        check(1'b0, "txn_length", tcnt, L);
                    tcnt = 0;
                end

                if (bus.i_ack) begin
                    check(!bus.mem_en && !bus.busy, "i_ack_turnaround", bus.mem_en, 0);
                    if (iq.size() == 0) begin
                        check(1'b0, "unexpected_i_ack", bus.i_line, 0);
                    end else begin
                        ea = iq.pop_front();
                        check(cyc == ea.cyc, "i_ack_cycle", cyc, ea.cyc);
                        check(bus.i_line == ea.line, "i_line", bus.i_line, ea.line);
                    end
                end
                if (bus.d_ack) begin
                    check(!bus.mem_en && !bus.busy, "d_ack_turnaround", bus.mem_en, 0);
                    if (dq.size() == 0) begin
                        check(1'b0, "unexpected_d_ack", bus.d_line, 0);
                    end else begin
                        ea = dq.pop_front();
                        check(cyc == ea.cyc, "d_ack_cycle", cyc, ea.cyc);
                        check(bus.d_line == ea.line, "d_line", bus.d_line, ea.line);
                    end
                end
            end
        end
    end

    // Raise requests in an idle cycle, predict the schedule, then drop each req after its ack.
    task automatic scenario(input bit ui, input bit ud, input bit uwb,
                            input logic [31:0] ia, input logic [31:0] da,
                            input logic [31:0] wa, input logic [127:0] wd);
        int c0;
        int t;
        int g;
        int budget;
        @(negedge clk);
        c0 = cyc;
        bus.i_req    = ui;
        bus.i_addr   = ia;
        bus.d_req    = ud;
        bus.d_wb     = uwb;
        bus.d_addr   = da;
        bus.d_wbaddr = wa;
        bus.d_wdata  = wd;

        // D wins; writeback phase then fill phase back to back; ack after the last phase.
        t = c0;
        if (ud) begin
            if (uwb) begin
                txq.push_back('{t + 1, 1'b1, wa, wd});
                refmem[wa] = wd;
                t = t + L;
            end
            txq.push_back('{t + 1, 1'b0, da, '0});
            dq.push_back('{t + L + 1, ref_rd(da)});
            t = t + L + 1;
        end
        if (ui) begin
            g = ud ? t + 1 : c0;
            txq.push_back('{g + 1, 1'b0, ia, '0});
            iq.push_back('{g + L + 1, ref_rd(ia)});
        end

        budget = 0;
        while ((bus.i_req || bus.d_req) && budget < 4 * L + 20) begin
            @(negedge clk);
            budget++;
            if (budget == 2)
                bus.d_wb = 1'($urandom_range(0, 1));
            if (bus.i_ack) bus.i_req = 1'b0;
            if (bus.d_ack) bus.d_req = 1'b0;
        end
        if (bus.i_req || bus.d_req) begin
            check(1'b0, "ack_timeout", {bus.i_req, bus.d_req}, 0);
            bus.i_req = 1'b0;
            bus.d_req = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int  c0;
        bit  got;
        bit  ui, ud;
        bit  exp_ack;

        bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_wb = 0;
        bus.d_addr = '0; bus.d_wbaddr = '0; bus.d_wdata = '0;
        bus1.i_req = 0; bus1.i_addr = '0; bus1.d_req = 0; bus1.d_wb = 0;
        bus1.d_addr = '0; bus1.d_wbaddr = '0; bus1.d_wdata = '0;
        reset = 1'b1;

        repeat (3) @(negedge clk);
        check(bus.i_ack == 0,     "rst_i_ack",     bus.i_ack, 0);
        check(bus.d_ack == 0,     "rst_d_ack",     bus.d_ack, 0);
        check(bus.mem_en == 0,    "rst_mem_en",    bus.mem_en, 0);
        check(bus.mem_we == 0,    "rst_mem_we",    bus.mem_we, 0);
        check(bus.busy == 0,      "rst_busy",      bus.busy, 0);
        check(bus.i_line == 0,    "rst_i_line",    bus.i_line, 0);
        check(bus.d_line == 0,    "rst_d_line",    bus.d_line, 0);
        check(bus.mem_addr == 0,  "rst_mem_addr",  bus.mem_addr, 0);
        check(bus.mem_wdata == 0, "rst_mem_wdata", bus.mem_wdata, 0);
        reset = 1'b0;
        @(posedge clk);
        mon_on = 1'b1;

        // Directed: lone I fill, D writeback+fill, simultaneous D and I.
        scenario(1, 0, 0, 32'h100, 32'h0,   32'h0,   '0);
        scenario(0, 1, 1, 32'h0,   32'h300, 32'h200, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE);
        scenario(1, 1, 0, 32'h400, 32'h500, 32'h0,   '0);

        // Reset during cycle 3 of an I fill aborts it; held request is regranted.
        @(posedge clk);
        mon_on = 1'b0;
        @(negedge clk);
        c0 = cyc;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h140;
        repeat (3) @(negedge clk);
        check(bus.mem_en == 1, "rst_mid_pre_en", bus.mem_en, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check(bus.mem_en == 0,   "rst_mid_mem_en",   bus.mem_en, 0);
        check(bus.i_ack == 0,    "rst_mid_i_ack",    bus.i_ack, 0);
        check(bus.busy == 0,     "rst_mid_busy",     bus.busy, 0);
        check(bus.mem_addr == 0, "rst_mid_mem_addr", bus.mem_addr, 0);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus.i_ack) begin
                got = 1'b1;
                check(cyc == c0 + 10, "rst_regrant_cycle", cyc, c0 + 10);
                check(bus.i_line == ref_rd(32'h140), "rst_regrant_line", bus.i_line, ref_rd(32'h140));
            end
        end
        if (!got) check(1'b0, "rst_regrant_timeout", 0, 1);
        bus.i_req = 1'b0;
        @(posedge clk);
        mon_on = 1'b1;

        // Random mixes of I/D requests with random gaps.
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ui = 1'($urandom_range(0, 1));
            ud = 1'($urandom_range(0, 1));
            if (!ui && !ud) ui = 1'b1;
            scenario(ui, ud, 1'($urandom_range(0, 1)), raddr(), raddr(), raddr(), rnd128());
        end

        repeat (4) @(negedge clk);
        check(txq.size() == 0, "txq_drained", txq.size(), 0);
        check(iq.size() == 0,  "iq_drained",  iq.size(), 0);
        check(dq.size() == 0,  "dq_drained",  dq.size(), 0);

        // MEM_LAT=1 with I request held: ack every third cycle, never with mem_en.
        @(negedge clk);
        c0 = cyc;
        bus1.i_addr = 32'h80;
        bus1.i_req  = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_ack = (k >= 2) && ((k - 2) % 3 == 0);
            check(bus1.i_ack == exp_ack, "lat1_ack_pattern", bus1.i_ack, exp_ack);
            check(bus1.mem_en == (k % 3 == 1), "lat1_mem_en", bus1.mem_en, (k % 3 == 1));
            if (bus1.i_ack)
                check(bus1.i_line == dflt(32'h80), "lat1_line", bus1.i_line, dflt(32'h80));
        end
        bus1.i_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
